svm_matmul_scheduler: RTL and testbench

Sequences the shared SVM ROM memory wrapper through the four matrix-multiply phases of one classification: V matmul1, V matmul2, A matmul1, A matmul2. It drives the one-hot phase flags and the `midx`/`comp_sidx` indices that select ROM addresses. It also tracks ROM read latency so the systolic datapath knows exactly which cycle carries valid support or alpha data. It sits between the top-level classifier FSM (start/done handshake) and the memory wrapper plus MAC array.

---
 rtl/svm_matmul_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_svm_matmul_scheduler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/svm_matmul_scheduler.sv
// Steps the shared SVM ROM through the V/A matmul1/matmul2 phases of one classification
// and carries {issue, phase, last} alongside the ROM latency so data cycles are flagged.
module svm_matmul_scheduler #(
  parameter int LOG_MIDX      = 7,
  parameter int LOG_SUP_WIDTH = 8,
  parameter int V_MIDX_COUNT  = 100,
  parameter int A_MIDX_COUNT  = 100,
  parameter int V_SUP_COUNT   = 214,
  parameter int A_SUP_COUNT   = 214,
  parameter int ROM_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic                     dp_stall,
  output logic                     computing_v_matmul1,
  output logic                     computing_v_matmul2,
  output logic                     computing_a_matmul1,
  output logic                     computing_a_matmul2,
  output logic [LOG_MIDX-1:0]      midx,
  output logic [LOG_SUP_WIDTH-1:0] comp_sidx,
  output logic                     rom_data_valid,
  output logic [1:0]               rom_data_phase,
  output logic                     rom_data_last,
  output logic                     done_valid,
  input  logic                     done_ready
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_V_MM1 = 3'd1,
    ST_V_MM2 = 3'd2,
    ST_A_MM1 = 3'd3,
    ST_A_MM2 = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  localparam logic [LOG_MIDX-1:0]      V_MIDX_LAST = LOG_MIDX'(V_MIDX_COUNT - 1);
  localparam logic [LOG_MIDX-1:0]      A_MIDX_LAST = LOG_MIDX'(A_MIDX_COUNT - 1);
  localparam logic [LOG_SUP_WIDTH-1:0] V_SUP_LAST  = LOG_SUP_WIDTH'(V_SUP_COUNT - 1);
  localparam logic [LOG_SUP_WIDTH-1:0] A_SUP_LAST  = LOG_SUP_WIDTH'(A_SUP_COUNT - 1);
  localparam logic [LOG_MIDX-1:0]      MIDX_ONE    = LOG_MIDX'(1);
  localparam logic [LOG_SUP_WIDTH-1:0] SIDX_ONE    = LOG_SUP_WIDTH'(1);
  localparam int                       PW          = 2 * ROM_LATENCY;

  state_e                   state_q, state_d;
  logic [LOG_MIDX-1:0]      midx_q, midx_d;
  logic [LOG_SUP_WIDTH-1:0] sidx_q, sidx_d;
  logic [ROM_LATENCY-1:0]   pipe_issue_q, pipe_issue_d;
  logic [ROM_LATENCY-1:0]   pipe_last_q, pipe_last_d;
  logic [PW-1:0]            pipe_phase_q, pipe_phase_d;
  logic [3:0]               flags_q, flags_d;
  logic                     start_ready_q, start_ready_d;
  logic                     done_valid_q, done_valid_d;
  logic                     issue_s, last_s;
  logic [1:0]               phase_s;
  logic [ROM_LATENCY-1:0]   issue_shift_s;

  // Next-state, index stepping and issue generation
  always_comb begin
    state_d       = state_q;
    midx_d        = midx_q;
    sidx_d        = sidx_q;
    issue_s       = 1'b0;
    last_s        = 1'b0;
    phase_s       = 2'd0;
    // DRAIN sees no new issue, so the shifted-in bit is always zero
    issue_shift_s = pipe_issue_q << 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          state_d = ST_V_MM1;
          midx_d  = '0;
          sidx_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_V_MM1: begin
        if (!dp_stall) begin
          issue_s = 1'b1;
          phase_s = 2'd0;
          if (midx_q == V_MIDX_LAST) begin
            last_s  = 1'b1;
            midx_d  = '0;
            state_d = ST_V_MM2;
          end else begin
            midx_d = midx_q + MIDX_ONE;
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_V_MM2: begin
        if (!dp_stall) begin
          issue_s = 1'b1;
          phase_s = 2'd1;
          if (sidx_q == V_SUP_LAST) begin
            last_s  = 1'b1;
            sidx_d  = '0;
            state_d = ST_A_MM1;
          end else begin
            sidx_d = sidx_q + SIDX_ONE;
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_A_MM1: begin
        if (!dp_stall) begin
          issue_s = 1'b1;
          phase_s = 2'd2;
          if (midx_q == A_MIDX_LAST) begin
            last_s  = 1'b1;
            midx_d  = '0;
            state_d = ST_A_MM2;
          end else begin
            midx_d = midx_q + MIDX_ONE;
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_A_MM2: begin
        if (!dp_stall) begin
          issue_s = 1'b1;
          phase_s = 2'd3;
          if (sidx_q == A_SUP_LAST) begin
            last_s  = 1'b1;
            sidx_d  = '0;
            state_d = ST_DRAIN;
          end else begin
            sidx_d = sidx_q + SIDX_ONE;
          end
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (issue_shift_s == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (done_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        midx_d  = '0;
        sidx_d  = '0;
      end
    endcase
  end

  // Latency tracking shift and registered output decode of the next state
  always_comb begin
    pipe_issue_d  = (pipe_issue_q << 1'b1) | ROM_LATENCY'(issue_s);
    pipe_last_d   = (pipe_last_q << 1'b1) | ROM_LATENCY'(last_s);
    pipe_phase_d  = (pipe_phase_q << 2'd2) | PW'(phase_s);
    start_ready_d = (state_d == ST_IDLE);
    done_valid_d  = (state_d == ST_DONE);
    case (state_d)
      ST_V_MM1: flags_d = 4'b0001;
      ST_V_MM2: flags_d = 4'b0010;
      ST_A_MM1: flags_d = 4'b0100;
      ST_A_MM2: flags_d = 4'b1000;
      default:  flags_d = 4'b0000;
    endcase
  end

  // State, indices, tracking pipeline and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      midx_q        <= '0;
      sidx_q        <= '0;
      pipe_issue_q  <= '0;
      pipe_last_q   <= '0;
      pipe_phase_q  <= '0;
      flags_q       <= 4'b0000;
      start_ready_q <= 1'b1;
      done_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      midx_q        <= midx_d;
      sidx_q        <= sidx_d;
      pipe_issue_q  <= pipe_issue_d;
      pipe_last_q   <= pipe_last_d;
      pipe_phase_q  <= pipe_phase_d;
      flags_q       <= flags_d;
      start_ready_q <= start_ready_d;
      done_valid_q  <= done_valid_d;
    end
  end

  assign computing_v_matmul1 = flags_q[0];
  assign computing_v_matmul2 = flags_q[1];
  assign computing_a_matmul1 = flags_q[2];
  assign computing_a_matmul2 = flags_q[3];
  assign midx                = midx_q;
  assign comp_sidx           = sidx_q;
  assign rom_data_valid      = pipe_issue_q[ROM_LATENCY-1];
  assign rom_data_last       = pipe_last_q[ROM_LATENCY-1];
  assign rom_data_phase      = pipe_phase_q[PW-1 -: 2];
  assign start_ready         = start_ready_q;
  assign done_valid          = done_valid_q;

endmodule

// File: tb/tb_svm_matmul_scheduler.sv
// Scoreboard bench: two schedulers (ROM latency 1 and 3, counts 3/2/3/2) share stimulus;
// expected issues, data beats and done cycles are queued by the stimulus and popped by a monitor.
module tb_svm_matmul_scheduler;

  localparam int LM = 7;
  localparam int LS = 8;

  typedef struct packed {
    int phase;
    int mi;
    int si;
    int last;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_valid = 1'b0;
  logic dp_stall = 1'b0;
  logic done_ready = 1'b1;

  logic [3:0]    fl0, fl1;
  logic [LM-1:0] mi0, mi1;
  logic [LS-1:0] si0, si1;
  logic          dv0, dv1, dl0, dl1, dn0, dn1, sr0, sr1;
  logic [1:0]    dp0, dp1;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t iss_q[$];
  exp_t dat_q0[$];
  exp_t dat_q1[$];
  int   done_exp[2];
  bit   done_pend[2];
  bit   prev_dn[2];
  bit   prev_hs[2];

  svm_matmul_scheduler #(
    .LOG_MIDX(LM), .LOG_SUP_WIDTH(LS),
    .V_MIDX_COUNT(3), .V_SUP_COUNT(2), .A_MIDX_COUNT(3), .A_SUP_COUNT(2),
    .ROM_LATENCY(1)
  ) dut_l1 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr0), .dp_stall(dp_stall),
    .computing_v_matmul1(fl0[0]), .computing_v_matmul2(fl0[1]),
    .computing_a_matmul1(fl0[2]), .computing_a_matmul2(fl0[3]),
    .midx(mi0), .comp_sidx(si0), .rom_data_valid(dv0), .rom_data_phase(dp0),
    .rom_data_last(dl0), .done_valid(dn0), .done_ready(done_ready)
  );

  svm_matmul_scheduler #(
    .LOG_MIDX(LM), .LOG_SUP_WIDTH(LS),
    .V_MIDX_COUNT(3), .V_SUP_COUNT(2), .A_MIDX_COUNT(3), .A_SUP_COUNT(2),
    .ROM_LATENCY(3)
  ) dut_l3 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(sr1), .dp_stall(dp_stall),
    .computing_v_matmul1(fl1[0]), .computing_v_matmul2(fl1[1]),
    .computing_a_matmul1(fl1[2]), .computing_a_matmul2(fl1[3]),
    .midx(mi1), .comp_sidx(si1), .rom_data_valid(dv1), .rom_data_phase(dp1),
    .rom_data_last(dl1), .done_valid(dn1), .done_ready(done_ready)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Hand table for counts 3/2/3/2: issue k -> phase, index within phase, last flag
  function automatic exp_t mk(input int k, input int c);
    exp_t e;
    int   idx;
    e.phase = (k < 3) ? 0 : (k < 5) ? 1 : (k < 8) ? 2 : 3;
    idx     = (k < 3) ? k : (k < 5) ? k - 3 : (k < 8) ? k - 5 : k - 8;
    e.mi    = (e.phase == 0 || e.phase == 2) ? idx : 0;
    e.si    = (e.phase == 1 || e.phase == 3) ? idx : 0;
    e.last  = (k == 2 || k == 4 || k == 7 || k == 9) ? 1 : 0;
    e.cyc   = c;
    return e;
  endfunction

  task automatic plan(input int s, input int stall_idx, input int stall_len, input int rc,
                      input bit want_done);
    int ic;
    ic = 0;
    for (int k = 0; k < 10; k++) begin
      ic = s + 1 + k + ((k >= stall_idx) ? stall_len : 0);
      if (ic < rc) iss_q.push_back(mk(k, ic));
      if (ic + 1 < rc) dat_q0.push_back(mk(k, ic + 1));
      if (ic + 3 < rc) dat_q1.push_back(mk(k, ic + 3));
    end
    if (want_done) begin
      done_exp[0]  = ic + 2;
      done_exp[1]  = ic + 4;
      done_pend[0] = 1'b1;
      done_pend[1] = 1'b1;
    end
  endtask

  task automatic check_flags(input logic [3:0] fl, input logic [LM-1:0] mi,
                             input logic [LS-1:0] si, input string tag);
    exp_t e;
    int   ph;
    chk({tag, "_onehot"}, int'($countones(fl) > 1), 0);
    if (fl == 4'b0000) begin
      chk({tag, "_idle_index"}, int'(mi) + int'(si), 0);
    end else if (iss_q.size() == 0) begin
      chk({tag, "_unexpected_issue"}, int'(fl), 0);
    end else begin
      e  = iss_q[0];
      ph = (fl == 4'b0001) ? 0 : (fl == 4'b0010) ? 1 : (fl == 4'b0100) ? 2 : 3;
      chk({tag, "_phase"}, ph, e.phase);
      chk({tag, "_midx"}, int'(mi), e.mi);
      chk({tag, "_comp_sidx"}, int'(si), e.si);
      if (!dp_stall) chk({tag, "_issue_cycle"}, cyc, e.cyc);
    end
  endtask

  task automatic check_data(input exp_t e, input logic [1:0] ph, input logic lst, input string tag);
    chk({tag, "_data_cycle"}, cyc, e.cyc);
    chk({tag, "_data_phase"}, int'(ph), e.phase);
    chk({tag, "_data_last"}, int'(lst), e.last);
  endtask

  task automatic check_done(input int d, input logic dn, input logic sr);
    if (prev_hs[d]) chk($sformatf("d%0d_done_release", d), int'(sr && !dn), 1);
    if (dn && !prev_dn[d]) begin
      chk($sformatf("d%0d_done_expected", d), int'(done_pend[d]), 1);
      chk($sformatf("d%0d_done_cycle", d), cyc, done_exp[d]);
      done_pend[d] = 1'b0;
    end
    prev_dn[d] = dn;
    prev_hs[d] = dn && done_ready;
  endtask

  // Monitor: sample away from the active edge and pop the scoreboards
  always @(negedge clk) begin
    check_flags(fl0, mi0, si0, "d0");
    check_flags(fl1, mi1, si1, "d1");
    if (fl0 != 4'b0000 && !dp_stall && iss_q.size() != 0) void'(iss_q.pop_front());
    if (dv0) begin
      if (dat_q0.size() == 0) chk("d0_unexpected_data", 1, 0);
      else check_data(dat_q0.pop_front(), dp0, dl0, "d0");
    end
    if (dv1) begin
      if (dat_q1.size() == 0) chk("d1_unexpected_data", 1, 0);
      else check_data(dat_q1.pop_front(), dp1, dl1, "d1");
    end
    check_done(0, dn0, sr0);
    check_done(1, dn1, sr1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_flags"}, int'(fl0) + int'(fl1), 0);
    chk({tag, "_midx"}, int'(mi0) + int'(mi1), 0);
    chk({tag, "_comp_sidx"}, int'(si0) + int'(si1), 0);
    chk({tag, "_data_valid"}, int'(dv0) + int'(dv1), 0);
    chk({tag, "_data_phase"}, int'(dp0) + int'(dp1), 0);
    chk({tag, "_data_last"}, int'(dl0) + int'(dl1), 0);
    chk({tag, "_done_valid"}, int'(dn0) + int'(dn1), 0);
    chk({tag, "_start_ready"}, int'(sr0 && sr1), 1);
  endtask

  task automatic run(input int stall_idx, input int stall_len, input string tag);
    int s;
    int n;
    tick();
    s = cyc;
    start_valid = 1'b1;
    plan(s, stall_idx, stall_len, 1 << 30, 1'b1);
    n = 0;
    do begin
      tick();
      n++;
      start_valid = 1'b0;
      dp_stall = (cyc >= s + 1 + stall_idx) && (cyc < s + 1 + stall_idx + stall_len);
    end while (!(n > 3 && sr0 && sr1) && n < 100);
    dp_stall = 1'b0;
    chk({tag, "_timeout"}, int'(n >= 100), 0);
    chk({tag, "_done_outstanding"}, int'(done_pend[0]) + int'(done_pend[1]), 0);
    chk({tag, "_issues_left"}, iss_q.size(), 0);
  endtask

  task automatic reset_run(input int rst_off);
    int s;
    tick();
    s = cyc;
    start_valid = 1'b1;
    plan(s, 99, 0, s + rst_off, 1'b0);
    while (cyc < s + rst_off) begin
      tick();
      start_valid = 1'b0;
    end
    rst = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    repeat (3) tick();
    rst = 1'b1;
    repeat (4) tick();
    check_reset_outputs("after_reset");
    chk("reset_issues_left", iss_q.size(), 0);
    chk("reset_data_left", dat_q0.size() + dat_q1.size(), 0);
  endtask

  task automatic done_hold_run();
    int s;
    int n;
    done_ready = 1'b0;
    tick();
    s = cyc;
    start_valid = 1'b1;
    plan(s, 99, 0, 1 << 30, 1'b1);
    n = 0;
    do begin
      tick();
      n++;
      start_valid = 1'b0;
    end while (!(dn0 && dn1) && n < 100);
    chk("hold_timeout", int'(n >= 100), 0);
    repeat (5) begin
      tick();
      start_valid = 1'b1;
      chk("hold_done_valid", int'(dn0 && dn1), 1);
      chk("hold_start_ready", int'(sr0 || sr1), 0);
    end
    tick();
    start_valid = 1'b0;
    done_ready  = 1'b1;
    tick();
    chk("hold_release_idle", int'(sr0 && sr1 && !dn0 && !dn1), 1);
    repeat (3) tick();
    chk("hold_no_restart", int'(fl0) + int'(fl1), 0);
  endtask

  initial begin
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (2) tick();
    check_reset_outputs("post_reset");
    run(99, 0, "nostall");
    run(1, 4, "stall_mid");
    run(4, 3, "stall_last");
    reset_run(7);
    run(99, 0, "restart");
    done_hold_run();
    repeat (5) tick();
    chk("final_issue_queue", iss_q.size(), 0);
    chk("final_data_queue_l1", dat_q0.size(), 0);
    chk("final_data_queue_l3", dat_q1.size(), 0);
    chk("final_done_pending", int'(done_pend[0]) + int'(done_pend[1]), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
